// File: rtl/mmio_stream_port.sv
// mmio_stream_port: memory-mapped TX FIFO on the core's data bus.
// The core pushes words through a 16-byte register window. The words drain
// on a valid/ready stream, and the core reads back status and controls
// flush/overflow through the same window.
//
// Stream handshake: a word transfers on every rising edge where out_valid
// and out_ready are both high. out_valid never depends combinationally on
// out_ready, and out_data is held stable while out_valid & !out_ready.
module mmio_stream_port #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [31:0] rd_data,
  output logic        rd_sel,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [31:0]   r_rd_data;
  logic          r_rd_sel;
  logic          r_out_valid;
  logic [31:0]   r_out_data;

  logic          w_hit;
  logic [1:0]    w_off;
  logic          w_empty;
  logic          w_full;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_ctrl_wr;
  logic          w_flush;
  logic          w_clr_ovf;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [31:0]   w_head_nxt;
  logic [31:0]   w_status;
  logic [31:0]   w_rd_val;
  logic          w_unused_addr;

  // Byte lane bits do not take part in decode.
  assign w_unused_addr = ^addr[1:0];

  assign w_hit      = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_off      = addr[3:2];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);

  // Fullness is judged on pre-edge state: a push to a full FIFO is dropped
  // even when a pop happens on the same edge.
  assign w_push_req = we & w_hit & (w_off == OFF_DATA);
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = r_out_valid & out_ready;
  assign w_ctrl_wr  = we & w_hit & (w_off == OFF_CTRL);
  assign w_flush    = w_ctrl_wr & wd[1];
  assign w_clr_ovf  = w_ctrl_wr & wd[0];

  assign w_status = {16'd0, 8'(r_count), 5'd0, r_overflow, w_full, w_empty};

  // Next pointer/count; flush wins over any pop on the same edge.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (w_flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      if (w_push) w_wr_ptr_nxt = r_wr_ptr + AW'(1);
      if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Next head word; bypass the write port when the new head is being written now.
  always_comb begin
    w_head_nxt = r_mem[w_rd_ptr_nxt];
    if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) w_head_nxt = wd;
  end

  // Register read mux; only STATUS returns data, everything else reads 0.
  always_comb begin
    w_rd_val = '0;
    if (w_hit && (w_off == OFF_STATUS)) w_rd_val = w_status;
  end

  // FIFO storage; contents are not cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wd;
  end

  // Pointers, count, sticky overflow, read port and stream output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_rd_data   <= '0;
      r_rd_sel    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      if (w_push_req && w_full) r_overflow <= 1'b1;
      else if (w_clr_ovf)       r_overflow <= 1'b0;
      r_rd_data   <= w_rd_val;
      r_rd_sel    <= w_hit;
      r_out_valid <= (w_count_nxt != '0);
      r_out_data  <= w_head_nxt;
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_sel    = r_rd_sel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: doc/mmio_stream_port.md
Name: mmio_stream_port

Overview:
- Memory-mapped responder on the core's data-memory bus (`data_memory_addr`, `data_memory_wd`, `data_memory_we`, `data_memory_data`), in parallel with the data RAM.
- The core writes words into a TX FIFO through an address window.
- The FIFO drains on a valid/ready stream toward an external consumer (UART/debug sink).
- The core reads status and controls flush/overflow through the same window. The system read mux selects `rd_data` when `rd_sel` is high.

Parameters:
- `BASE_ADDR`, 32'h0000_0400, base of the 16-byte register window; `BASE_ADDR[3:0]` must be 0.
- `DEPTH`, 8, FIFO entries; power of 2, range 2..128.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `addr`  in  32  data bus address from core.
- `wd`  in  32  data bus write data.
- `we`  in  1  data bus write enable.
- `rd_data`  out  32  registered read data.
- `rd_sel`  out  1  registered window hit; qualifies `rd_data` for the read mux.
- `out_valid`  out  1  stream word available.
- `out_data`  out  32  stream word (FIFO head).
- `out_ready`  in  1  consumer accepts word.

Behaviour:
- Reset (reset=0, async): wr_ptr, rd_ptr and count go to 0; overflow goes to 0; `rd_data`=0; `rd_sel`=0; `out_valid`=0; `out_data`=0. All state is released on the first `clk` edge after reset=1.
- Address decode: hit = (`addr[31:4]` == `BASE_ADDR[31:4]`). Offset = `addr[3:2]`. `addr[1:0]` is ignored.
- Register map:
  - Offset 0 DATA: write-only; reads return 0.
  - Offset 1 STATUS: read-only.
    - bit0 empty
    - bit1 full
    - bit2 overflow (sticky)
    - bits[15:8] count, zero-extended
    - all other bits 0
  - Offset 2 CTRL: write-only; reads return 0.
    - bit0 = 1 clears overflow.
    - bit1 = 1 flushes the FIFO.
  - Offset 3: reserved. Reads return 0; writes are ignored.
- Read timing: the core issues no read strobe, so a read is implied every cycle.
  - Each edge: `rd_sel` <= hit; `rd_data` <= hit ? reg(offset) : 0.
  - Latency is 1 cycle, matching the data RAM.
  - STATUS reflects state before that edge's updates.
- Push: occurs when `we` & hit & offset 0.
  - If not full (pre-edge state): mem[wr_ptr] <= `wd`, wr_ptr increments modulo DEPTH, count increments.
  - If full: the word is dropped and overflow <= 1. Fullness is judged on pre-edge state, so a push to a full FIFO is dropped even if a pop happens on the same edge.
- Pop: occurs when `out_valid` & `out_ready`. rd_ptr increments modulo DEPTH, count decrements.
- Simultaneous push and pop with 0 < count < DEPTH: both take effect; count is unchanged.
- Stream output:
  - `out_valid` = (count != 0), registered.
  - `out_data` = mem[rd_ptr].
  - No fall-through: a word pushed into an empty FIFO at edge N gives `out_valid`=1 after edge N.
  - `out_data` is held stable while `out_valid` & !`out_ready`.
- Flush (CTRL bit1): ptrs and count go to 0. Flush takes priority over a pop on the same edge. Stored contents are not cleared. `out_valid` drops after the edge.
- CTRL write with bits0 and 1 both set: both actions apply on the same edge.
- Clear-overflow versus a simultaneous overflow event: not possible on the same edge because DATA and CTRL are distinct addresses. Overflow stays set until it is cleared or reset.
- Writes outside the window have no effect. Non-hit cycles force `rd_data` to 0.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits. Full = (count == DEPTH).

Test Plan:
1. Reset then idle, `out_ready`=1 → `out_valid`=0. Read STATUS at 0x404 → `rd_sel`=1 and `rd_data`=32'h0000_0001 one cycle later.
2. Write 0xA, 0xB, 0xC to 0x400 with `out_ready`=0 → STATUS=32'h0000_0300. Raise `out_ready` → `out_data` shows 0xA, 0xB, 0xC on consecutive cycles; `out_valid` falls after the third pop.
3. `out_ready`=0; write 9 words (0x1..0x9), DEPTH=8 → STATUS=32'h0000_0806 (full + overflow). Drain gives exactly 0x1..0x8.
4. With the FIFO full, a push and a pop on the same edge → pushed word is dropped, count=7, overflow set. Write CTRL=1 → overflow clears; STATUS bit2=0.
5. Fill 5 words, then write CTRL=2 while `out_ready`=1 → FIFO empties; `out_valid`=0 the next cycle; STATUS=32'h0000_0001.
6. Assert reset low asynchronously mid-drain (between edges) → `out_valid`, `rd_sel`, `rd_data` go to 0 immediately. After release, a read of 0x290 (outside window) gives `rd_sel`=0 and `rd_data`=0.
